// File: rtl/arb_pkg.sv
// Shared definitions for the 8-way round-robin arbiter.
//   NUM_REQ     : number of requesters
//   IDX_W       : width of a requester index
//   arb_state_e : two-state arbitration FSM encoding
//   rr_pick     : round-robin winner search starting after the last owner
package arb_pkg;

    localparam int NUM_REQ = 8;
    localparam int IDX_W   = 3;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_e;

    // Returns the first set request bit in the order last+1, last+2, ...
    // wrapping naturally in IDX_W bits. The last owner itself is searched
    // last, so it only wins again when nobody else is requesting.
    // Callers guarantee req is non-zero.
    function automatic logic [IDX_W-1:0] rr_pick(
        input logic [NUM_REQ-1:0] req,
        input logic [IDX_W-1:0]   last
    );
        logic [IDX_W-1:0] pick;
        logic [IDX_W-1:0] cand;
        logic             found;
        pick  = last;
        found = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = last + IDX_W'(k);
            if (!found && req[cand]) begin
                pick  = cand;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/grant_dec3to8.sv
// Combinational 3-to-8 one-hot decoder with enable.
//   idx_i : binary index
//   en_i  : output is all-zero when low
//   oh_o  : one-hot decode of idx_i, gated by en_i
module grant_dec3to8
    import arb_pkg::*;
(
    input  logic [IDX_W-1:0]   idx_i,
    input  logic               en_i,
    output logic [NUM_REQ-1:0] oh_o
);

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_dec
            assign oh_o[gi] = en_i && (idx_i == IDX_W'(gi));
        end
    endgenerate

endmodule

// File: rtl/arbiter_8way.sv
// Eight-requester round-robin arbiter with bounded grant tenure.
//   MAX_HOLD  : maximum tenure in cycles before a contended owner is preempted
//   clk       : clock, rising edge
//   rst       : synchronous active-high reset
//   req       : request levels, bit i = requester i
//   gnt       : registered one-hot grant, zero when no owner
//   gnt_idx   : binary index of the owner, zero when no owner
//   gnt_valid : high while an owner holds the grant
//   preempt   : one-cycle pulse in the guard cycle after a timeout release
// Every owner change passes through at least one IDLE cycle with gnt=0.
module arbiter_8way
    import arb_pkg::*;
#(
    parameter int MAX_HOLD = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDX_W-1:0]   gnt_idx,
    output logic               gnt_valid,
    output logic               preempt
);

    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

    arb_state_e       state_q, state_d;
    logic [IDX_W-1:0] gnt_idx_q, gnt_idx_d;
    logic [IDX_W-1:0] last_idx_q, last_idx_d;
    logic [7:0]       hold_cnt_q, hold_cnt_d;
    logic             preempt_q, preempt_d;

    logic             owner_req;
    logic             other_req;

    assign gnt_valid = (state_q == BUSY);
    assign gnt_idx   = gnt_idx_q;
    assign preempt   = preempt_q;

    grant_dec3to8 u_dec (
        .idx_i (gnt_idx_q),
        .en_i  (gnt_valid),
        .oh_o  (gnt)
    );

    // Only meaningful in BUSY, where gnt is the owner's one-hot mask.
    assign owner_req = req[gnt_idx_q];
    assign other_req = |(req & ~gnt);

    always_comb begin
        state_d    = state_q;
        gnt_idx_d  = gnt_idx_q;
        last_idx_d = last_idx_q;
        hold_cnt_d = hold_cnt_q;
        preempt_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (|req) begin
                    gnt_idx_d  = rr_pick(req, last_idx_q);
                    last_idx_d = rr_pick(req, last_idx_q);
                    hold_cnt_d = 8'd0;
                    state_d    = BUSY;
                end
            end
            BUSY: begin
                // Release takes priority over timeout, so a simultaneous
                // drop of the owner's request never pulses preempt.
                if (!owner_req) begin
                    state_d   = IDLE;
                    gnt_idx_d = '0;
                end else if (hold_cnt_q == HOLD_LAST && other_req) begin
                    state_d   = IDLE;
                    gnt_idx_d = '0;
                    preempt_d = 1'b1;
                end else if (hold_cnt_q != HOLD_LAST) begin
                    hold_cnt_d = hold_cnt_q + 8'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            gnt_idx_q  <= '0;
            last_idx_q <= IDX_W'(NUM_REQ - 1);
            hold_cnt_q <= 8'd0;
            preempt_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            gnt_idx_q  <= gnt_idx_d;
            last_idx_q <= last_idx_d;
            hold_cnt_q <= hold_cnt_d;
            preempt_q  <= preempt_d;
        end
    end

endmodule

// File: tb/tb_arbiter_8way.sv
// Directed testbench for arbiter_8way (MAX_HOLD=4).
module tb_arbiter_8way;

    logic       clk;
    logic       rst;
    logic [7:0] req;
    logic [7:0] gnt;
    logic [2:0] gnt_idx;
    logic       gnt_valid;
    logic       preempt;

    int checks_cnt;
    int errors_cnt;

    arbiter_8way #(.MAX_HOLD(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid),
        .preempt   (preempt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks_cnt++;
        if (act !== exp) begin
            errors_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Advance one edge, then sample 1 time unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Checks the full output set against an expected owner (or none).
    task automatic expect_out(input string tag, input logic [7:0] exp_gnt,
                              input logic [2:0] exp_idx, input logic exp_pre);
        check_val({tag, ".gnt"}, 32'(gnt), 32'(exp_gnt));
        check_val({tag, ".idx"}, 32'(gnt_idx), 32'(exp_idx));
        check_val({tag, ".valid"}, 32'(gnt_valid), 32'(exp_gnt != 8'h00));
        check_val({tag, ".preempt"}, 32'(preempt), 32'(exp_pre));
        $display("%s: req=%02h gnt=%02h idx=%0d valid=%0b preempt=%0b",
                 tag, req, gnt, gnt_idx, gnt_valid, preempt);
    endtask

    initial begin
        logic [7:0] own;
        checks_cnt = 0;
        errors_cnt = 0;
        rst = 1'b1;
        req = 8'h00;
        tick();
        tick();
        expect_out("reset", 8'h00, 3'd0, 1'b0);
        rst = 1'b0;

        // Single requester grant and release
        req = 8'h01;
        tick();
        expect_out("single_grant", 8'h01, 3'd0, 1'b0);
        req = 8'h00;
        tick();
        expect_out("single_release", 8'h00, 3'd0, 1'b0);

        // Full rotation from reset priority, 2-cycle tenures
        rst = 1'b1;
        tick();
        rst = 1'b0;
        req = 8'hFF;
        tick();
        for (int i = 0; i < 9; i++) begin
            own = 8'h01 << (i % 8);
            expect_out($sformatf("rot%0d_c0", i), own, 3'(i % 8), 1'b0);
            tick();
            expect_out($sformatf("rot%0d_c1", i), own, 3'(i % 8), 1'b0);
            req = 8'hFF & ~own;
            tick();
            expect_out($sformatf("rot%0d_guard", i), 8'h00, 3'd0, 1'b0);
            req = (i == 8) ? 8'h00 : 8'hFF;
            tick();
        end
        // last owner was 0; bus idle now
        expect_out("rot_idle", 8'h00, 3'd0, 1'b0);

        // Preemption: owner 2 contended by 5
        req = 8'h04;
        tick();
        expect_out("pre_h0", 8'h04, 3'd2, 1'b0);
        req = 8'h24;
        for (int i = 1; i < 4; i++) begin
            tick();
            expect_out($sformatf("pre_h%0d", i), 8'h04, 3'd2, 1'b0);
        end
        tick();
        expect_out("pre_pulse", 8'h00, 3'd0, 1'b1);
        tick();
        expect_out("pre_next", 8'h20, 3'd5, 1'b0);
        req = 8'h00;
        tick();
        expect_out("pre_done", 8'h00, 3'd0, 1'b0);

        // Uncontended owner 3 keeps the grant past the timeout
        req = 8'h08;
        for (int i = 0; i < 20; i++) begin
            tick();
            expect_out($sformatf("hold%0d", i), 8'h08, 3'd3, 1'b0);
        end
        req = 8'h00;
        tick();
        expect_out("hold_done", 8'h00, 3'd0, 1'b0);

        // Release coincides with timeout while 6 waits: no preempt
        req = 8'h10;
        tick();
        expect_out("coinc_h0", 8'h10, 3'd4, 1'b0);
        req = 8'h50;
        for (int i = 1; i < 4; i++) begin
            tick();
            expect_out($sformatf("coinc_h%0d", i), 8'h10, 3'd4, 1'b0);
        end
        req = 8'h40;
        tick();
        expect_out("coinc_rel", 8'h00, 3'd0, 1'b0);
        tick();
        expect_out("coinc_next", 8'h40, 3'd6, 1'b0);
        req = 8'h00;
        tick();
        expect_out("coinc_done", 8'h00, 3'd0, 1'b0);

        // Reset during a grant, then priority restarts at 0
        req = 8'h10;
        tick();
        expect_out("rst_busy", 8'h10, 3'd4, 1'b0);
        rst = 1'b1;
        tick();
        expect_out("rst_drop", 8'h00, 3'd0, 1'b0);
        rst = 1'b0;
        req = 8'h90;
        tick();
        expect_out("rst_resume", 8'h10, 3'd4, 1'b0);
        req = 8'h00;
        tick();
        expect_out("final", 8'h00, 3'd0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks_cnt, errors_cnt);
        $finish;
    end

endmodule
